// File: rtl/multiplier_pkg.sv
// -----------------------------------------------------------------------------
// multiplier_pkg
// Shared types and helpers for the pipelined multiplier.
//   mul_mode_e          : per-beat arithmetic mode (unsigned / two's complement)
//   MUL_DEFAULT_LATENCY : default number of pipeline register stages
//   MUL_EXT_MAX         : widest operand extension supported by mul_extend;
//                         WIDTH_A + WIDTH_B must not exceed it
//   mul_extend()        : sign- or zero-extends an operand of run-time width
// Optional feature macro used by the other files: MULTIPLIER_TAG_EN.
// -----------------------------------------------------------------------------
package multiplier_pkg;

    typedef enum logic {
        MUL_UNSIGNED = 1'b0,
        MUL_SIGNED   = 1'b1
    } mul_mode_e;

    localparam int unsigned MUL_DEFAULT_LATENCY = 32'd3;
    localparam int unsigned MUL_EXT_MAX         = 32'd256;

    // Extend the low 'width' bits of 'value' to MUL_EXT_MAX bits. The sign bit
    // is fetched with a shift rather than a variable index so the helper stays
    // width-agnostic for any operand size up to MUL_EXT_MAX.
    function automatic logic [MUL_EXT_MAX-1:0] mul_extend(
        input logic [MUL_EXT_MAX-1:0] value,
        input int unsigned            width,
        input mul_mode_e              mode
    );
        logic [MUL_EXT_MAX-1:0] upper_mask;
        logic [MUL_EXT_MAX-1:0] shifted;
        logic                   fill;
        upper_mask = {MUL_EXT_MAX{1'b1}} << width;
        shifted    = value >> (width - 32'd1);
        fill       = (mode == MUL_SIGNED) ? shifted[0] : 1'b0;
        return (value & ~upper_mask) | (fill ? upper_mask : {MUL_EXT_MAX{1'b0}});
    endfunction

endpackage

// File: rtl/multiplier_pipelined_if.sv
// -----------------------------------------------------------------------------
// multiplier_pipelined_if
// Operand/product handshake bundle for multiplier_pipelined.
//   in_valid/in_ready   : operand beat handshake
//   in_signed, a, b     : beat mode and operands
//   out_valid/out_ready : product handshake
//   q                   : product, WIDTH_A+WIDTH_B bits
//   in_tag/out_tag      : sideband tag, present only with MULTIPLIER_TAG_EN
// Modports: master = producer/consumer side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface multiplier_pipelined_if #(
    parameter int WIDTH_A = 64,
    parameter int WIDTH_B = 64
`ifdef MULTIPLIER_TAG_EN
    ,
    parameter int TAG_WIDTH = 8
`endif
);

    logic                       in_valid;
    logic                       in_ready;
    logic                       in_signed;
    logic [WIDTH_A-1:0]         a;
    logic [WIDTH_B-1:0]         b;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH_A+WIDTH_B-1:0] q;
`ifdef MULTIPLIER_TAG_EN
    logic [TAG_WIDTH-1:0]       in_tag;
    logic [TAG_WIDTH-1:0]       out_tag;
`endif

`ifdef MULTIPLIER_TAG_EN
    modport master (
        output in_valid, in_signed, a, b, out_ready, in_tag,
        input  in_ready, out_valid, q, out_tag
    );
    modport slave (
        input  in_valid, in_signed, a, b, out_ready, in_tag,
        output in_ready, out_valid, q, out_tag
    );
`else
    modport master (
        output in_valid, in_signed, a, b, out_ready,
        input  in_ready, out_valid, q
    );
    modport slave (
        input  in_valid, in_signed, a, b, out_ready,
        output in_ready, out_valid, q
    );
`endif

endinterface

// File: rtl/multiplier_pipe_reg.sv
// -----------------------------------------------------------------------------
// multiplier_pipe_reg
// One stall-aware pipeline stage: valid bit, data word, mode and optional tag.
//   clk, rstn   : clock, synchronous active-low reset
//   stall       : hold current contents when high
//   load_*      : values captured at the next edge when not stalled
//   valid, data, mode, tag : registered stage contents
// Tag fields exist only with MULTIPLIER_TAG_EN.
// -----------------------------------------------------------------------------
module multiplier_pipe_reg
    import multiplier_pkg::*;
#(
    parameter int DATA_W = 128
`ifdef MULTIPLIER_TAG_EN
    ,
    parameter int TAG_W = 8
`endif
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  mul_mode_e         load_mode,
`ifdef MULTIPLIER_TAG_EN
    input  logic [TAG_W-1:0]  load_tag,
    output logic [TAG_W-1:0]  tag,
`endif
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output mul_mode_e         mode
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    mul_mode_e         mode_r;
`ifdef MULTIPLIER_TAG_EN
    logic [TAG_W-1:0]  tag_r;
`endif

    // Stage register: clear on reset, load when the pipe moves, else hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
            mode_r  <= MUL_UNSIGNED;
`ifdef MULTIPLIER_TAG_EN
            tag_r   <= {TAG_W{1'b0}};
`endif
        end else if (!stall) begin
            valid_r <= load_valid;
            data_r  <= load_data;
            mode_r  <= load_mode;
`ifdef MULTIPLIER_TAG_EN
            tag_r   <= load_tag;
`endif
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
            mode_r  <= mode_r;
`ifdef MULTIPLIER_TAG_EN
            tag_r   <= tag_r;
`endif
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign mode  = mode_r;
`ifdef MULTIPLIER_TAG_EN
    assign tag   = tag_r;
`endif

endmodule

// File: rtl/multiplier_pipelined.sv
// -----------------------------------------------------------------------------
// multiplier_pipelined
// Fully pipelined WIDTH_A x WIDTH_B multiplier with valid/ready on both sides
// and a per-beat signed/unsigned mode. One product per cycle when not stalled.
//   clk  : clock
//   rstn : synchronous active-low reset, discards every in-flight beat
//   bus  : multiplier_pipelined_if.slave (operands in, product out)
// Parameters: WIDTH_A, WIDTH_B (>=2, sum <= MUL_EXT_MAX), LATENCY (>=1),
//             TAG_WIDTH (exists only with MULTIPLIER_TAG_EN).
// Optional feature macro: MULTIPLIER_TAG_EN adds in_tag/out_tag that ride
// along with each beat.
// -----------------------------------------------------------------------------
module multiplier_pipelined
    import multiplier_pkg::*;
#(
    parameter int WIDTH_A = 64,
    parameter int WIDTH_B = 64,
    parameter int LATENCY = MUL_DEFAULT_LATENCY
`ifdef MULTIPLIER_TAG_EN
    ,
    parameter int TAG_WIDTH = 8
`endif
) (
    input logic                   clk,
    input logic                   rstn,
    multiplier_pipelined_if.slave bus
);

    localparam int PROD_W = WIDTH_A + WIDTH_B;

    logic                   stall_s;
    logic [LATENCY-1:0]     load_valid_s;
    logic [PROD_W-1:0]      load_data_s  [LATENCY];
    mul_mode_e              load_mode_s  [LATENCY];
    logic [LATENCY-1:0]     stage_valid_s;
    logic [PROD_W-1:0]      stage_data_s [LATENCY];
    mul_mode_e              stage_mode_s [LATENCY];
`ifdef MULTIPLIER_TAG_EN
    logic [TAG_WIDTH-1:0]   load_tag_s   [LATENCY];
    logic [TAG_WIDTH-1:0]   stage_tag_s  [LATENCY];
`endif

    logic [WIDTH_A-1:0]     mul_a_raw_s;
    logic [WIDTH_B-1:0]     mul_b_raw_s;
    mul_mode_e              mul_mode_s;
    logic [MUL_EXT_MAX-1:0] mul_a_ext_s;
    logic [MUL_EXT_MAX-1:0] mul_b_ext_s;
    logic [PROD_W-1:0]      product_s;

    // The whole pipe freezes only when the head holds a product nobody takes;
    // bubbles are deliberately not squeezed out.
    assign stall_s      = stage_valid_s[LATENCY-1] & ~bus.out_ready;
    assign bus.in_ready = ~stall_s;

    // Both operands are extended to the full product width in the beat's own
    // mode; the low PROD_W bits of that product are exact in either mode.
    assign mul_a_ext_s = mul_extend(MUL_EXT_MAX'(mul_a_raw_s), WIDTH_A, mul_mode_s);
    assign mul_b_ext_s = mul_extend(MUL_EXT_MAX'(mul_b_raw_s), WIDTH_B, mul_mode_s);
    assign product_s   = PROD_W'(mul_a_ext_s * mul_b_ext_s);

    // With a single stage the product must be formed before it; otherwise
    // stage 1 keeps the raw operands and the multiply sits between stage 1
    // and stage 2 so the input path stays short.
    generate
        if (LATENCY == 1) begin : g_mul_front
            assign mul_a_raw_s    = bus.a;
            assign mul_b_raw_s    = bus.b;
            assign mul_mode_s     = mul_mode_e'(bus.in_signed);
            assign load_data_s[0] = product_s;
        end else begin : g_mul_stage1
            assign mul_a_raw_s    = stage_data_s[0][PROD_W-1:WIDTH_B];
            assign mul_b_raw_s    = stage_data_s[0][WIDTH_B-1:0];
            assign mul_mode_s     = stage_mode_s[0];
            assign load_data_s[0] = {bus.a, bus.b};
        end
    endgenerate

    assign load_valid_s[0] = bus.in_valid & ~stall_s;
    assign load_mode_s[0]  = mul_mode_e'(bus.in_signed);
`ifdef MULTIPLIER_TAG_EN
    assign load_tag_s[0]   = bus.in_tag;
`endif

    generate
        for (genvar i = 1; i < LATENCY; i++) begin : g_link
            assign load_valid_s[i] = stage_valid_s[i-1];
            assign load_mode_s[i]  = stage_mode_s[i-1];
`ifdef MULTIPLIER_TAG_EN
            assign load_tag_s[i]   = stage_tag_s[i-1];
`endif
            if (i == 1) begin : g_take_product
                assign load_data_s[i] = product_s;
            end else begin : g_take_prev
                assign load_data_s[i] = stage_data_s[i-1];
            end
        end

        for (genvar i = 0; i < LATENCY; i++) begin : g_stage
            multiplier_pipe_reg #(
                .DATA_W (PROD_W)
`ifdef MULTIPLIER_TAG_EN
                ,
                .TAG_W  (TAG_WIDTH)
`endif
            ) u_stage (
                .clk        (clk),
                .rstn       (rstn),
                .stall      (stall_s),
                .load_valid (load_valid_s[i]),
                .load_data  (load_data_s[i]),
                .load_mode  (load_mode_s[i]),
`ifdef MULTIPLIER_TAG_EN
                .load_tag   (load_tag_s[i]),
                .tag        (stage_tag_s[i]),
`endif
                .valid      (stage_valid_s[i]),
                .data       (stage_data_s[i]),
                .mode       (stage_mode_s[i])
            );
        end
    endgenerate

    assign bus.out_valid = stage_valid_s[LATENCY-1];
    assign bus.q         = stage_data_s[LATENCY-1];
`ifdef MULTIPLIER_TAG_EN
    assign bus.out_tag   = stage_tag_s[LATENCY-1];
`endif

endmodule
